pc_stack: RTL

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pc_stack.sv
//==============================================================================
// Module      : pc_stack
// Description : Program counter with a small hardware return-address stack.
//               Supports increment, jump (load), call (push return address and
//               jump) and return (pop into the program counter), with sticky
//               overflow/underflow flags and a wrap-around build option.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   ADDR_W    : program counter / return-address width in bits (default 12)
//   DEPTH     : number of return-stack entries, legal range 2..16 (default 4)
//
// Build option
//   PC_STACK_WRAP_EN : when defined, a call on a full stack discards the
//                      oldest entry and pushes the new return address on top
//                      (overflow untouched). When undefined, a call on a full
//                      stack leaves the stack alone and sets overflow.
//
// Ports
//   clock       in   rising-edge clock for all state
//   reset       in   asynchronous, active-high reset
//   enable      in   increment pc by 1
//   load        in   jump: pc takes load_data
//   call        in   push pc+1, pc takes load_data
//   ret         in   pop top of stack into pc
//   flag_clr    in   clear sticky overflow/underflow
//   load_data   in   [ADDR_W]            jump/call target address
//   pc          out  [ADDR_W]            registered program counter
//   depth       out  [clog2(DEPTH+1)]    registered count of valid entries
//   stack_full  out  depth == DEPTH
//   stack_empty out  depth == 0
//   overflow    out  sticky: call attempted while full (non-wrap build)
//   underflow   out  sticky: ret attempted while empty
//
// Command priority on each edge: ret > call > load > enable.
//==============================================================================

`default_nettype none

module pc_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       flag_clr,
    input  logic [ADDR_W-1:0]          load_data,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [DW-1:0] C_DEPTH_FULL = DW'(DEPTH);
    localparam logic [DW-1:0] C_DEPTH_ZERO = '0;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [DW-1:0]     depth_q;
    logic [DW-1:0]     depth_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              underflow_q;
    logic              underflow_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];

    //--------------------------------------------------------------------------
    // Helper signals
    //--------------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_inc;       // return address / increment target
    logic [ADDR_W-1:0] top_entry;    // stack[depth-1], valid only when not empty
    logic              is_full;
    logic              is_empty;
    logic              set_overflow;
    logic              set_underflow;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign is_full  = (depth_q == C_DEPTH_FULL);
    assign is_empty = (depth_q == C_DEPTH_ZERO);

    // Top-of-stack read. A compare-select loop is used instead of a direct
    // array index so the depth counter (one bit wider than the entry index
    // for power-of-two DEPTH) never has to be truncated.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == (depth_q - DW'(1))) begin
                top_entry = stack_q[i];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        depth_d       = depth_q;
        stack_d       = stack_q;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;

        if (ret) begin
            if (!is_empty) begin
                pc_d    = top_entry;
                depth_d = depth_q - DW'(1);
            end else begin
                // Return with nothing stacked: pc holds, flag the fault.
                set_underflow = 1'b1;
            end
        end else if (call) begin
            pc_d = load_data;
            if (!is_full) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (DW'(i) == depth_q) begin
                        stack_d[i] = pc_inc;
                    end
                end
                depth_d = depth_q + DW'(1);
            end else begin
`ifdef PC_STACK_WRAP_EN
                // Drop the oldest entry (slot 0), shift everything down and
                // place the new return address on top. Depth stays at DEPTH.
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[DEPTH-1] = pc_inc;
`else
                // Stack contents are preserved; the lost return address is
                // reported through the sticky overflow flag.
                set_overflow = 1'b1;
`endif
            end
        end else if (load) begin
            pc_d = load_data;
        end else if (enable) begin
            pc_d = pc_inc;
        end
    end

    // Sticky flags: a setting event on the same edge beats flag_clr.
    always_comb begin
        overflow_d  = (overflow_q  & ~flag_clr) | set_overflow;
        underflow_d = (underflow_q & ~flag_clr) | set_underflow;
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

`default_nettype wire
